// File: rtl/alu_mux_pkg.sv
// Shared types for the 3:1 x 2-bit ALU operand mux and its upstream sequencer.
package alu_mux_pkg;
  localparam int N_SRC = 3;
  localparam int W     = 2;

  typedef logic [1:0] src_idx_t;

  typedef struct packed {
    logic [W-1:0] data;
    src_idx_t     src;
  } out_word_t;

  // Source index increment with wrap 2 -> 0; encoding 3 is never produced.
  function automatic src_idx_t next_idx(input src_idx_t i);
    return (i >= src_idx_t'(N_SRC - 1)) ? '0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/alu_mux3.sv
// Generated 3:1 x W-bit operand mux: one bit-slice instance per data bit.
module alu_mux3_bit
  import alu_mux_pkg::*;
(
  input  logic [N_SRC-1:0] d,
  input  src_idx_t         sel,
  output logic             y
);
  always_comb begin
    y = 1'b0;
    case (sel)
      2'd0:    y = d[0];
      2'd1:    y = d[1];
      2'd2:    y = d[2];
      default: y = 1'b0;
    endcase
  end
endmodule

module alu_mux3
  import alu_mux_pkg::*;
(
  input  logic [N_SRC*W-1:0] in_data,
  input  src_idx_t           sel,
  output logic [W-1:0]       out_data
);
  logic [W-1:0][N_SRC-1:0] lane_d;

  for (genvar b = 0; b < W; b++) begin : g_bit
    for (genvar s = 0; s < N_SRC; s++) begin : g_src
      assign lane_d[b][s] = in_data[s*W + b];
    end
    alu_mux3_bit u_bit (
      .d   (lane_d[b]),
      .sel (sel),
      .y   (out_data[b])
    );
  end
endmodule

// File: rtl/rr_grant3.sv
// Combinational 3-way round-robin pick: search starts one past the last winner.
module rr_grant3
  import alu_mux_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output logic             gnt_vld,
  output src_idx_t         idx
);
  src_idx_t ord0, ord1, ord2;

  always_comb begin
    ord0    = next_idx(ptr);
    ord1    = next_idx(ord0);
    ord2    = next_idx(ord1);
    gnt_vld = 1'b0;
    idx     = '0;
    // Evaluate lowest priority first so the highest-priority hit wins last.
    if (req[ord2]) begin gnt_vld = 1'b1; idx = ord2; end
    if (req[ord1]) begin gnt_vld = 1'b1; idx = ord1; end
    if (req[ord0]) begin gnt_vld = 1'b1; idx = ord0; end
  end
endmodule

// File: rtl/rr_mux3_sequencer.sv
// Round-robin arbiter over 3 valid/ready sources feeding a 1-deep registered
// output stage; sel drives the shared 3:1 operand mux.
module rr_mux3_sequencer
  import alu_mux_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   in_valid,
  input  logic [N_SRC*W-1:0] in_data,
  output logic [N_SRC-1:0]   in_ready,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready
);
  src_idx_t     ptr;
  src_idx_t     gnt_idx;
  logic         gnt_vld;
  logic         can_accept;
  logic         fire;
  logic [W-1:0] mux_data;
  out_word_t    out_q;

  rr_grant3 u_grant (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .idx     (gnt_idx)
  );

  alu_mux3 u_mux (
    .in_data  (in_data),
    .sel      (gnt_idx),
    .out_data (mux_data)
  );

  // sel depends only on in_valid and ptr, never on out_ready.
  assign sel        = gnt_idx;
  assign can_accept = !out_valid || out_ready;
  assign in_ready   = (can_accept && gnt_vld) ? (N_SRC'(1) << gnt_idx) : '0;
  assign fire       = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      ptr       <= src_idx_t'(N_SRC - 1);
    end else if (fire) begin
      out_valid  <= 1'b1;
      out_q.data <= mux_data;
      out_q.src  <= gnt_idx;
      ptr        <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = out_q.data;
  assign out_src  = out_q.src;
endmodule

// File: tb/tb_rr_mux3_sequencer.sv
// Directed bench for rr_mux3_sequencer: reset, round-robin, wrap, stall, idle.
module tb_rr_mux3_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_valid;
  logic [5:0] in_data;
  logic [2:0] in_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [1:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  rr_mux3_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 3'b000; in_data = 6'b10_01_11; out_ready = 1'b0;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 2'b00) begin fails++; $display("FAIL reset_data got %b exp 00", out_data); end
    tests++; if (out_src !== 2'd0) begin fails++; $display("FAIL reset_src got %0d exp 0", out_src); end
    rst_n = 1'b1;
    in_valid = 3'b010;
    tick();
    in_valid = 3'b000;
    tests++; if (out_valid !== 1'b1 || out_data !== 2'b01 || out_src !== 2'd1) begin
      fails++; $display("FAIL pre_async_load got v=%b d=%b s=%0d exp v=1 d=01 s=1", out_valid, out_data, out_src); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 2'b00 || out_src !== 2'd0) begin
      fails++; $display("FAIL async_reset got v=%b d=%b s=%0d exp v=0 d=00 s=0", out_valid, out_data, out_src); end
    tick();
    rst_n = 1'b1;
    in_valid = 3'b111;
    #1;
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL post_reset_sel got %0d exp 0", sel); end
    tests++; if (in_ready !== 3'b001) begin fails++; $display("FAIL post_reset_ready got %b exp 001", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_d [3];
    exp_d[0] = 2'b11; exp_d[1] = 2'b01; exp_d[2] = 2'b10;
    in_valid = 3'b111; in_data = 6'b10_01_11; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || out_src !== 2'(k % 3) || out_data !== exp_d[k % 3]) begin
        fails++; $display("FAIL rr_cycle%0d got v=%b s=%0d d=%b exp v=1 s=%0d d=%b",
                          k, out_valid, out_src, out_data, k % 3, exp_d[k % 3]); end
    end
  endtask

  task automatic test_skip_wrap();
    in_valid = 3'b010;
    tick();
    tests++; if (out_src !== 2'd1) begin fails++; $display("FAIL wrap_setup_src got %0d exp 1", out_src); end
    in_valid = 3'b001;
    #1;
    tests++; if (sel !== 2'd0 || in_ready !== 3'b001) begin
      fails++; $display("FAIL wrap_sel0 got sel=%0d rdy=%b exp sel=0 rdy=001", sel, in_ready); end
    tick();
    in_valid = 3'b101;
    #1;
    tests++; if (sel !== 2'd2 || in_ready !== 3'b100) begin
      fails++; $display("FAIL skip_sel2 got sel=%0d rdy=%b exp sel=2 rdy=100", sel, in_ready); end
    tick();
    tests++; if (out_src !== 2'd2 || out_data !== 2'b10) begin
      fails++; $display("FAIL skip_load got s=%0d d=%b exp s=2 d=10", out_src, out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (in_ready !== 3'b000 || sel !== 2'd1) begin
        fails++; $display("FAIL stall%0d_ready got rdy=%b sel=%0d exp rdy=000 sel=1", k, in_ready, sel); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_data !== 2'b10 || out_src !== 2'd2) begin
        fails++; $display("FAIL stall%0d_hold got v=%b d=%b s=%0d exp v=1 d=10 s=2", k, out_valid, out_data, out_src); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 3'b010) begin fails++; $display("FAIL unstall_ready got %b exp 010", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 2'b01 || out_src !== 2'd1) begin
      fails++; $display("FAIL drain_fill got v=%b d=%b s=%0d exp v=1 d=01 s=1", out_valid, out_data, out_src); end
  endtask

  task automatic test_idle();
    in_valid = 3'b000; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 3'b000 || sel !== 2'd0) begin
      fails++; $display("FAIL idle_comb got rdy=%b sel=%0d exp rdy=000 sel=0", in_ready, sel); end
    tick();
    tests++; if (out_valid !== 1'b0 || out_data !== 2'b01 || out_src !== 2'd1) begin
      fails++; $display("FAIL idle_drain got v=%b d=%b s=%0d exp v=0 d=01 s=1", out_valid, out_data, out_src); end
    tick();
    in_valid = 3'b111;
    #1;
    tests++; if (sel !== 2'd2 || in_ready !== 3'b100) begin
      fails++; $display("FAIL idle_ptr_hold got sel=%0d rdy=%b exp sel=2 rdy=100", sel, in_ready); end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    out_ready = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin
      fails++; $display("FAIL mid_stall_setup got v=%b s=%0d exp v=1 s=2", out_valid, out_src); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stall_reset got v=%b exp 0", out_valid); end
    tick();
    rst_n = 1'b1;
    #1;
    tests++; if (sel !== 2'd0 || in_ready !== 3'b001) begin
      fails++; $display("FAIL post_stall_grant got sel=%0d rdy=%b exp sel=0 rdy=001", sel, in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 2'b11) begin
      fails++; $display("FAIL post_stall_load got v=%b s=%0d d=%b exp v=1 s=0 d=11", out_valid, out_src, out_data); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_idle();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
